alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one combinational ALU (operands A/B, opcode OP, result ALU_OUT; 8 ops: add, sub, mul, div, mod, and, or, xor) between two requesters.
- Accepts one operation at a time via valid/ready, arbitrates round-robin, and drives the ALU operand/opcode inputs from registers.
- Captures the ALU result and returns it with requester ID on a valid/ready response channel.
- Sits between the two operation sources and the shared ALU instance.

Parameters:
- W, 3, operand width; must match ALU operand width.
- RW, 5, result width; must match ALU result width.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- REQ0_VALID  input  1  requester 0 has an operation
- REQ0_A  input  W  requester 0 operand A
- REQ0_B  input  W  requester 0 operand B
- REQ0_OP  input  3  requester 0 opcode
- REQ0_READY  output  1  requester 0 operation accepted this cycle
- REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP, REQ1_READY  same as requester 0, for requester 1
- ALU_A  output  W  registered operand A to ALU
- ALU_B  output  W  registered operand B to ALU
- ALU_OP  output  3  registered opcode to ALU
- ALU_OUT  input  RW  combinational result from ALU
- RES_VALID  output  1  response valid
- RES_READY  input  1  response consumer ready
- RES_DATA  output  RW  captured result
- RES_ID  output  1  requester that issued the op
- RES_ERR  output  1  error flag (see Optional Feature)
- OPS_DONE  output  CNT_W  count of completed responses

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE; round-robin pointer PRI=0 (requester 0 favoured).
  - rst mid-operation aborts the op, discards any pending response, and returns to IDLE next edge.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Nothing happens if neither VALID is high.
  - If exactly one VALID is high, that requester is granted.
  - If both are high, the PRI requester is granted.
  - Grant pulses that requester's READY combinationally for one cycle (the handshake cycle).
  - On the edge: latch A/B/OP into ALU_A/ALU_B/ALU_OP, latch ID, go to EXEC.
  - READY is never high outside IDLE; at most one READY is high per cycle.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable.
  - On the edge: RES_DATA<=ALU_OUT, RES_ID<=latched ID, RES_ERR per feature, RES_VALID<=1, go to RESP.
- RESP:
  - RES_VALID, RES_DATA, RES_ID and RES_ERR are held stable until RES_READY is high at an edge.
  - On that edge: RES_VALID<=0, OPS_DONE increments, PRI<=~RES_ID, go to IDLE.
  - A new request is accepted no earlier than the cycle after RES_VALID falls.
- Latency:
  - Handshake at cycle N; RES_VALID rises at N+2.
  - With RES_READY held high, throughput is one op per 3 cycles.
- Requesters' VALID/operands may change freely while not granted; operands are sampled only in the handshake cycle.
- ALU_A/B/OP hold their last values in IDLE and RESP.
- RES_DATA is the raw ALU_OUT; no truncation or extension in this block. SUB underflow wraps mod 2^RW as produced by the ALU (e.g. 1-2 = 5'b11111).
- OPS_DONE wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: ALU_DIVZERO_CHK_EN.
- Defined:
  - RES_ERR=1 when the latched OP is 3'b011 or 3'b100 and latched B==0.
  - In that case RES_DATA is forced to {RW{1'b1}} instead of ALU_OUT.
  - Otherwise RES_ERR=0.
- Undefined: RES_ERR is tied 0 and RES_DATA is always ALU_OUT.

Test Plan:
- Reset hold, then REQ0 only with A=3, B=2, OP=000, RES_READY=1:
  - REQ0_READY pulses at cycle N.
  - RES_VALID at N+2 with DATA=5, ID=0.
  - OPS_DONE=1.
- Both VALID high continuously after reset, RES_READY=1:
  - Grants alternate 0,1,0,1.
  - REQ1 with A=7, B=3, OP=100 returns DATA=1, ID=1.
- Backpressure: RES_READY=0 for 5 cycles after RES_VALID:
  - DATA/ID held and RES_VALID stays high.
  - No READY is issued until 1 cycle after RES_READY is accepted.
- REQ0 A=1, B=2, OP=001 -> DATA=5'b11111, ERR=0.
- REQ1 A=6, B=0, OP=011:
  - With ALU_DIVZERO_CHK_EN: ERR=1, DATA=5'b11111.
  - Without: ERR=0, DATA=ALU_OUT.
- Assert rst in EXEC:
  - Next cycle RES_VALID=0, OPS_DONE=0, PRI=0.
  - Then both VALID -> requester 0 granted first.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin two-requester front end for one shared combinational ALU
// Optional divide/modulo-by-zero flagging is built when ALU_DIVZERO_CHK_EN is defined.
module alu_req_arbiter #(
    parameter int W     = 3,
    parameter int RW    = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             REQ0_VALID,
    input  logic [W-1:0]     REQ0_A,
    input  logic [W-1:0]     REQ0_B,
    input  logic [2:0]       REQ0_OP,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [W-1:0]     REQ1_A,
    input  logic [W-1:0]     REQ1_B,
    input  logic [2:0]       REQ1_OP,
    output logic             REQ1_READY,
    output logic [W-1:0]     ALU_A,
    output logic [W-1:0]     ALU_B,
    output logic [2:0]       ALU_OP,
    input  logic [RW-1:0]    ALU_OUT,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [RW-1:0]    RES_DATA,
    output logic             RES_ID,
    output logic             RES_ERR,
    output logic [CNT_W-1:0] OPS_DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic          pri;
    logic          lat_id;
    logic          gnt0;
    logic          gnt1;
    logic          err_nxt;
    logic [RW-1:0] data_nxt;

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !rst) begin
            gnt0 = REQ0_VALID && (!REQ1_VALID || !pri);
            gnt1 = REQ1_VALID && (!REQ0_VALID ||  pri);
        end
    end

    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;

`ifdef ALU_DIVZERO_CHK_EN
    always_comb begin
        err_nxt  = (ALU_OP == 3'b011 || ALU_OP == 3'b100) && (ALU_B == '0);
        data_nxt = err_nxt ? {RW{1'b1}} : ALU_OUT;
    end
`else
    always_comb begin
        err_nxt  = 1'b0;
        data_nxt = ALU_OUT;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pri       <= 1'b0;
            lat_id    <= 1'b0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_OP    <= '0;
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_ID    <= 1'b0;
            RES_ERR   <= 1'b0;
            OPS_DONE  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        ALU_A  <= gnt1 ? REQ1_A  : REQ0_A;
                        ALU_B  <= gnt1 ? REQ1_B  : REQ0_B;
                        ALU_OP <= gnt1 ? REQ1_OP : REQ0_OP;
                        lat_id <= gnt1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    RES_DATA  <= data_nxt;
                    RES_ID    <= lat_id;
                    RES_ERR   <= err_nxt;
                    RES_VALID <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        OPS_DONE  <= OPS_DONE + CNT_W'(1);
                        pri       <= ~RES_ID;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

    localparam int W     = 3;
    localparam int RW    = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             REQ0_VALID, REQ1_VALID;
    logic [W-1:0]     REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [2:0]       REQ0_OP, REQ1_OP;
    logic             REQ0_READY, REQ1_READY;
    logic [W-1:0]     ALU_A, ALU_B;
    logic [2:0]       ALU_OP;
    logic [RW-1:0]    ALU_OUT;
    logic             RES_VALID, RES_READY;
    logic [RW-1:0]    RES_DATA;
    logic             RES_ID, RES_ERR;
    logic [CNT_W-1:0] OPS_DONE;

    int checks = 0;
    int errors = 0;

    alu_req_arbiter #(.W(W), .RW(RW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_OP(REQ0_OP), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_OP(REQ1_OP), .REQ1_READY(REQ1_READY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_OUT(ALU_OUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .RES_ID(RES_ID), .RES_ERR(RES_ERR), .OPS_DONE(OPS_DONE)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU; division by zero yields 0 here.
    always_comb begin
        ALU_OUT = '0;
        case (ALU_OP)
            3'b000: ALU_OUT = RW'(ALU_A) + RW'(ALU_B);
            3'b001: ALU_OUT = RW'(ALU_A) - RW'(ALU_B);
            3'b010: ALU_OUT = RW'(ALU_A) * RW'(ALU_B);
            3'b011: ALU_OUT = (ALU_B == 0) ? '0 : RW'(ALU_A / ALU_B);
            3'b100: ALU_OUT = (ALU_B == 0) ? '0 : RW'(ALU_A % ALU_B);
            3'b101: ALU_OUT = RW'(ALU_A & ALU_B);
            3'b110: ALU_OUT = RW'(ALU_A | ALU_B);
            default: ALU_OUT = RW'(ALU_A ^ ALU_B);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (REQ0_READY) begin id = 0; break; end
            if (REQ1_READY) begin id = 1; break; end
        end
        if (id < 0) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_resp();
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (RES_VALID) begin seen = 1; break; end
        end
        if (!seen) check("resp_timeout", 0, 1);
    endtask

    int gnt_q[$], gnt_cyc[$], rdat_q[$], rid_q[$], rcyc_q[$];
    int both_ready, held_bad, early_ready, gid;
    logic [RW-1:0] exp_dz;
    logic          exp_dz_err;

    initial begin
`ifdef ALU_DIVZERO_CHK_EN
        exp_dz = 5'b11111; exp_dz_err = 1'b1;
`else
        exp_dz = 5'b00000; exp_dz_err = 1'b0;
`endif
        rst = 1'b1; RES_READY = 1'b0;
        REQ0_VALID = 0; REQ0_A = 0; REQ0_B = 0; REQ0_OP = 0;
        REQ1_VALID = 0; REQ1_A = 0; REQ1_B = 0; REQ1_OP = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", RES_VALID, 0);
        check("rst_res_data", RES_DATA, 0);
        check("rst_alu_a", ALU_A, 0);
        check("rst_ops_done", OPS_DONE, 0);
        check("rst_res_err", RES_ERR, 0);

        // Single request from requester 0: 3 + 2.
        @(posedge clk); #1;
        rst = 1'b0; RES_READY = 1'b1;
        REQ0_VALID = 1; REQ0_A = 3; REQ0_B = 2; REQ0_OP = 3'b000;
        @(negedge clk);
        check("t1_ready0", REQ0_READY, 1);
        check("t1_ready1", REQ1_READY, 0);
        @(posedge clk); #1;
        REQ0_VALID = 0; REQ0_A = 7;
        @(negedge clk);
        check("t1_exec_ready0", REQ0_READY, 0);
        check("t1_exec_valid", RES_VALID, 0);
        check("t1_alu_a", ALU_A, 3);
        @(negedge clk);
        check("t1_valid_n2", RES_VALID, 1);
        check("t1_data", RES_DATA, 5);
        check("t1_id", RES_ID, 0);
        check("t1_err", RES_ERR, 0);
        @(negedge clk);
        check("t1_valid_fall", RES_VALID, 0);
        check("t1_ops_done", OPS_DONE, 1);
        check("t1_alu_a_hold", ALU_A, 3);

        // Both requesters continuously valid after a fresh reset.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        REQ0_VALID = 1; REQ0_A = 1; REQ0_B = 2; REQ0_OP = 3'b001;
        REQ1_VALID = 1; REQ1_A = 7; REQ1_B = 3; REQ1_OP = 3'b100;
        both_ready = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (REQ0_READY && REQ1_READY) both_ready++;
            if (REQ0_READY) begin gnt_q.push_back(0); gnt_cyc.push_back(c); end
            if (REQ1_READY) begin gnt_q.push_back(1); gnt_cyc.push_back(c); end
            if (RES_VALID) begin
                rdat_q.push_back(int'(RES_DATA)); rid_q.push_back(int'(RES_ID)); rcyc_q.push_back(c);
            end
        end
        @(posedge clk); #1; REQ0_VALID = 0; REQ1_VALID = 0;
        check("t2_both_ready", both_ready, 0);
        check("t2_grant_count", gnt_q.size(), 4);
        check("t2_resp_count", rdat_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gnt_q.size()) check($sformatf("t2_grant%0d", k), gnt_q[k], k % 2);
            if (k < rdat_q.size()) begin
                check($sformatf("t2_data%0d", k), rdat_q[k], (k % 2) ? 1 : 31);
                check($sformatf("t2_id%0d", k), rid_q[k], k % 2);
                if (k < gnt_cyc.size()) check($sformatf("t2_lat%0d", k), rcyc_q[k] - gnt_cyc[k], 2);
            end
        end
        @(negedge clk);
        check("t2_ops_done", OPS_DONE, 4);

        // Divide by zero from requester 1 under backpressure; requester 0 waits.
        @(posedge clk); #1;
        RES_READY = 1'b0;
        REQ1_VALID = 1; REQ1_A = 6; REQ1_B = 0; REQ1_OP = 3'b011;
        wait_grant(gid);
        check("t3_grant", gid, 1);
        @(posedge clk); #1;
        REQ1_VALID = 0;
        REQ0_VALID = 1; REQ0_A = 2; REQ0_B = 3; REQ0_OP = 3'b010;
        wait_resp();
        check("t3_dz_data", RES_DATA, exp_dz);
        check("t3_dz_err", RES_ERR, exp_dz_err);
        check("t3_dz_id", RES_ID, 1);
        held_bad = 0; early_ready = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!RES_VALID || RES_DATA !== exp_dz || RES_ID !== 1'b1) held_bad++;
            if (REQ0_READY || REQ1_READY) early_ready++;
        end
        check("t3_held", held_bad, 0);
        check("t3_no_ready", early_ready, 0);
        @(posedge clk); #1; RES_READY = 1'b1;
        @(negedge clk);
        check("t3_ready_accept_cycle", REQ0_READY, 0);
        @(negedge clk);
        check("t3_ready_after", REQ0_READY, 1);
        check("t3_valid_fall", RES_VALID, 0);
        check("t3_ops_done", OPS_DONE, 5);
        @(posedge clk); #1; REQ0_VALID = 0;
        wait_resp();
        check("t3_mul_data", RES_DATA, 6);
        check("t3_mul_id", RES_ID, 0);
        @(negedge clk);
        check("t3_ops_done2", OPS_DONE, 6);

        // Reset during EXEC; pointer currently favours requester 1.
        @(posedge clk); #1;
        REQ0_VALID = 1; REQ0_A = 1; REQ0_B = 1; REQ0_OP = 3'b000;
        REQ1_VALID = 1; REQ1_A = 2; REQ1_B = 2; REQ1_OP = 3'b000;
        @(negedge clk);
        check("t4_grant1", REQ1_READY, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("t4_valid", RES_VALID, 0);
        check("t4_ops_done", OPS_DONE, 0);
        check("t4_ready0", REQ0_READY, 1);
        check("t4_ready1", REQ1_READY, 0);
        @(posedge clk); #1; REQ0_VALID = 0; REQ1_VALID = 0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
